// File: rtl/cv32e40x_aes_pkg.sv
// Shared AES definitions: datapath widths and the mask bundle type consumed
// by the masked AES32 unit.
//   SHAREB_W   : width of the share-B field fed to the S-box
//   RAND_W     : width of the fresh randomness field
//   MASK_W     : full bundle width (SHAREB_W + RAND_W)
//   ENT_W      : width of one RNG entropy word
//   aes_mask_t : {randombits, share_b}, share_b in the low bits
package cv32e40x_aes_pkg;

  localparam int unsigned SHAREB_W = 8;
  localparam int unsigned RAND_W   = 36;
  localparam int unsigned MASK_W   = SHAREB_W + RAND_W;
  localparam int unsigned ENT_W    = 32;

  // 'rand' is a reserved word, so the randomness field is named randombits
  // after the AES port it feeds.
  typedef struct packed {
    logic [RAND_W-1:0]   randombits;
    logic [SHAREB_W-1:0] share_b;
  } aes_mask_t;

endpackage

// File: rtl/cv32e40x_aes_mask_pool_if.sv
// Entropy-in / mask-out handshake bundle of the AES mask pool.
//   ent_valid_i/ent_data_i/ent_ready_o : RNG word handshake
//   mask_valid_o/mask_ready_i          : mask bundle handshake
//   share_b_o/rand_o                   : current bundle fields
// slave  : the mask pool side
// master : the RNG / AES / bench side
interface cv32e40x_aes_mask_pool_if;
  import cv32e40x_aes_pkg::*;

  logic                ent_valid_i;
  logic [ENT_W-1:0]    ent_data_i;
  logic                ent_ready_o;
  logic                mask_valid_o;
  logic                mask_ready_i;
  logic [SHAREB_W-1:0] share_b_o;
  logic [RAND_W-1:0]   rand_o;

  modport slave (
    input  ent_valid_i, ent_data_i, mask_ready_i,
    output ent_ready_o, mask_valid_o, share_b_o, rand_o
  );

  modport master (
    output ent_valid_i, ent_data_i, mask_ready_i,
    input  ent_ready_o, mask_valid_o, share_b_o, rand_o
  );

endinterface

// File: rtl/cv32e40x_aes_rng_health.sv
// Repetition health test for RNG words.
//   clk, reset : clock, synchronous active-high reset
//   accept     : a word is handshaken this cycle
//   data       : the handshaken word
//   flush      : drop history; a word handshaken now is ignored
//   pass       : word differs from the last stored word (or no history)
//   err        : registered one-cycle pulse after a rejected word
//   cnt        : saturating count of rejected words (cleared only by reset)
module cv32e40x_aes_rng_health
  import cv32e40x_aes_pkg::*;
#(
  parameter bit EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             accept,
  input  logic [ENT_W-1:0] data,
  input  logic             flush,
  output logic             pass,
  output logic             err,
  output logic [7:0]       cnt
);

  logic [ENT_W-1:0] last_q;
  logic             last_vld_q;
  logic             reject;

  assign pass   = !EN || !last_vld_q || (data != last_q);
  assign reject = accept && !pass && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
    end else begin
      err <= reject;
      if (flush) begin
        last_vld_q <= 1'b0;
      end else if (accept && pass) begin
        last_q     <= data;
        last_vld_q <= 1'b1;
      end
      if (reject && (cnt != '1)) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/cv32e40x_aes_mask_pool.sv
// Entropy pool in front of the masked AES32 unit. Packs 32-bit RNG words into
// an LSB-aligned bit pool and hands out 44-bit mask bundles.
//   clk, reset    : clock, synchronous active-high reset
//   bus (slave)   : RNG word handshake in, mask bundle handshake out
//   flush_i       : discard all buffered entropy (key/context change)
//   rep_err_o     : one-cycle pulse after a word rejected as a repeat
//   rep_err_cnt_o : saturating count of rejected words
module cv32e40x_aes_mask_pool
  import cv32e40x_aes_pkg::*;
#(
  parameter int unsigned POOL_BUNDLES = 2,
  parameter bit          REP_CHECK_EN = 1'b1
) (
  input  logic                             clk,
  input  logic                             reset,
  cv32e40x_aes_mask_pool_if.slave          bus,
  input  logic                             flush_i,
  output logic                             rep_err_o,
  output logic [7:0]                       rep_err_cnt_o
);

  localparam int unsigned POOL_W  = MASK_W * POOL_BUNDLES;
  localparam int unsigned NIB_N   = POOL_W / 4;
  localparam int unsigned ENT_NIB = ENT_W / 4;
  localparam int unsigned FW      = $clog2(POOL_W + 1);

  localparam logic [FW-1:0] FILL_MASK    = FW'(MASK_W);
  localparam logic [FW-1:0] FILL_ENT     = FW'(ENT_W);
  localparam logic [FW-1:0] FILL_RDY_MAX = FW'(POOL_W - ENT_W);

  logic [POOL_W-1:0] pool_q, pool_post, pool_d;
  logic [FW-1:0]     fill_q, fill_post, fill_d;
  logic              ent_ready, mask_valid;
  logic              accept, consume, pass, store;
  int unsigned       nib_off;
  aes_mask_t         head;

  assign ent_ready  = (fill_q <= FILL_RDY_MAX);
  assign mask_valid = (fill_q >= FILL_MASK);
  assign accept     = bus.ent_valid_i && ent_ready;
  assign consume    = bus.mask_ready_i && mask_valid;
  assign store      = accept && pass;

  cv32e40x_aes_rng_health #(
    .EN (REP_CHECK_EN)
  ) u_health (
    .clk    (clk),
    .reset  (reset),
    .accept (accept),
    .data   (bus.ent_data_i),
    .flush  (flush_i),
    .pass   (pass),
    .err    (rep_err_o),
    .cnt    (rep_err_cnt_o)
  );

  // Consume first, then insert the new word at the post-consume fill so it
  // lands directly after the remaining bits. Bits above fill are always zero,
  // so only the eight nibbles at the insert offset are written.
  always_comb begin
    pool_post = consume ? (pool_q >> MASK_W) : pool_q;
    fill_post = consume ? (fill_q - FILL_MASK) : fill_q;
    nib_off   = 32'(fill_post) >> 2;
    pool_d    = pool_post;
    fill_d    = fill_post;
    if (store) begin
      for (int unsigned k = 0; k < NIB_N; k++) begin
        for (int unsigned j = 0; j < ENT_NIB; j++) begin
          if ((k >= j) && ((k - j) == nib_off)) begin
            pool_d[4*k +: 4] = bus.ent_data_i[4*j +: 4];
          end
        end
      end
      fill_d = fill_post + FILL_ENT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      pool_q <= '0;
      fill_q <= '0;
    end else begin
      pool_q <= pool_d;
      fill_q <= fill_d;
    end
  end

  // A partial bundle is never exposed on the outputs.
  assign head             = pool_q[MASK_W-1:0];
  assign bus.ent_ready_o  = ent_ready;
  assign bus.mask_valid_o = mask_valid;
  assign bus.share_b_o    = mask_valid ? head.share_b : '0;
  assign bus.rand_o       = mask_valid ? head.randombits : '0;

endmodule

// File: tb/tb_cv32e40x_aes_mask_pool.sv
module tb_cv32e40x_aes_mask_pool;
  import cv32e40x_aes_pkg::*;

  localparam int POOL_W = 88;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       rep_err;
  logic [7:0] rep_cnt;

  cv32e40x_aes_mask_pool_if bus();

  cv32e40x_aes_mask_pool #(
    .POOL_BUNDLES (2),
    .REP_CHECK_EN (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .flush_i       (flush),
    .rep_err_o     (rep_err),
    .rep_err_cnt_o (rep_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the pool is a plain bit stream; complete bundles are
  // cut off the front of the stream into the expected-bundle queue.
  int          mfill;
  bit          bitq[$];
  logic [43:0] expq[$];
  logic [31:0] last_word;
  bit          last_vld;
  bit          exp_err;
  int          exp_cnt;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    mfill = 0;
    bitq.delete();
    expq.delete();
    last_vld = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic check_state();
    chk("ent_ready", bus.ent_ready_o, (mfill <= POOL_W - 32));
    chk("mask_valid", bus.mask_valid_o, (mfill >= 44));
    chk("rep_err", rep_err, exp_err);
    chk("rep_cnt", rep_cnt, exp_cnt[7:0]);
  endtask

  task automatic step(input bit ev, input logic [31:0] ed, input bit mr, input bit fl);
    bit          rdy, vld, acc, cons, nerr;
    logic [43:0] b;
    check_state();
    rdy  = (mfill <= POOL_W - 32);
    vld  = (mfill >= 44);
    bus.ent_valid_i  = ev;
    bus.ent_data_i   = ed;
    bus.mask_ready_i = mr;
    flush            = fl;
    acc  = ev && rdy;
    cons = mr && vld;
    nerr = 1'b0;
    if (fl) begin
      model_clear();
    end else begin
      if (cons) mfill -= 44;
      if (acc) begin
        if (last_vld && (ed == last_word)) begin
          nerr = 1'b1;
          if (exp_cnt < 255) exp_cnt++;
        end else begin
          last_word = ed;
          last_vld  = 1'b1;
          mfill += 32;
          for (int i = 0; i < 32; i++) bitq.push_back(ed[i]);
          while (bitq.size() >= 44) begin
            for (int i = 0; i < 44; i++) b[i] = bitq.pop_front();
            expq.push_back(b);
          end
        end
      end
    end
    exp_err = nerr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    bus.ent_valid_i  = 1'b0;
    bus.ent_data_i   = '0;
    bus.mask_ready_i = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    exp_cnt = 0;
  endtask

  // Monitor: whenever a bundle is presented, it must be the oldest expected
  // one; it leaves the scoreboard when the consumer takes it.
  always @(negedge clk) begin
    if (!reset && !flush && bus.mask_valid_o) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL bundle_unexpected got=%0h exp=none", {bus.rand_o, bus.share_b_o});
      end else begin
        chk("share_b", bus.share_b_o, expq[0][7:0]);
        chk("rand", bus.rand_o, expq[0][43:8]);
        if (bus.mask_ready_i) void'(expq.pop_front());
      end
    end
  end

  initial begin
    logic [11:0] tail;
    logic [31:0] w, prev;
    int          k;

    exp_cnt = 0;
    model_clear();
    do_reset();

    // Reset state
    chk("rst_share_b", bus.share_b_o, 8'h00);
    chk("rst_rand", bus.rand_o, 36'h0);
    check_state();

    // Two back-to-back words from empty
    step(1'b1, 32'h11111111, 1'b0, 1'b0);
    chk("valid_n1", bus.mask_valid_o, 1'b0);
    step(1'b1, 32'h22222222, 1'b0, 1'b0);
    chk("valid_n2", bus.mask_valid_o, 1'b1);
    chk("first_bundle", {bus.rand_o, bus.share_b_o}, 44'h22211111111);

    // Pool full (64 > 56): words refused, outputs held
    for (int i = 0; i < 4; i++) step(1'b1, 32'h33330000 + i, 1'b0, 1'b0);
    chk("full_ready", bus.ent_ready_o, 1'b0);
    chk("full_hold", {bus.rand_o, bus.share_b_o}, 44'h22211111111);

    // Walk the fill to 56, then consume and accept together
    k = 0;
    for (int i = 0; i < 40; i++) begin
      if (mfill == 56) break;
      if (mfill <= 56) begin
        step(1'b1, 32'hA5000000 + k, 1'b0, 1'b0);
        k++;
      end else begin
        step(1'b0, '0, 1'b1, 1'b0);
      end
    end
    for (int i = 0; i < 12; i++) tail[i] = bitq[i];
    step(1'b1, 32'hC0FFEE01, 1'b1, 1'b0);
    chk("merge_bundle", {bus.rand_o, bus.share_b_o}, {32'hC0FFEE01, tail});
    chk("merge_ready", bus.ent_ready_o, 1'b1);

    // Repetition test from an empty pool
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("rep_pulse", rep_err, 1'b1);
    chk("rep_cnt_one", rep_cnt, 8'd1);
    chk("rep_no_fill", bus.mask_valid_o, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rep_pulse_end", rep_err, 1'b0);

    // Flush at fill=64 with a consume request
    step(1'b1, 32'h12345678, 1'b0, 1'b0);
    step(1'b1, 32'h9ABCDEF0, 1'b1, 1'b1);
    chk("flush_valid", bus.mask_valid_o, 1'b0);
    chk("flush_share_b", bus.share_b_o, 8'h00);
    chk("flush_rand", bus.rand_o, 36'h0);
    step(1'b1, 32'h12345678, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("post_flush_noerr", rep_cnt, 8'd1);

    // Saturation of the error counter, then reset clears it
    for (int i = 0; i < 300; i++) step(1'b1, 32'h5A5A5A5A, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("cnt_saturated", rep_cnt, 8'd255);
    do_reset();
    chk("cnt_reset", rep_cnt, 8'd0);
    chk("reset_valid", bus.mask_valid_o, 1'b0);

    // Randomized traffic with repeats and occasional flushes
    prev = 32'h0BADF00D;
    for (int i = 0; i < 500; i++) begin
      w = ($urandom_range(0, 3) == 0) ? prev : $urandom;
      prev = w;
      step(($urandom_range(0, 3) != 0), w, $urandom_range(0, 1) == 1,
           ($urandom_range(0, 39) == 0));
    end
    check_state();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
